// File: rtl/pick_pkg.sv
// pick_pkg -- shared types and defaults for the pick controller.
//   pick_ctrl_state_t : controller state encoding (legacy-compatible constants)
//   DEF_NUM_PIX / DEF_NUM_LINES / DEF_TIMEOUT : default parameter values
//   LINE_IDX_W        : width of the line index output
//   state_busy()      : BUSY decode shared by the controller
package pick_pkg;

    localparam int unsigned DEF_NUM_PIX   = 16;
    localparam int unsigned DEF_NUM_LINES = 8;
    localparam int unsigned DEF_TIMEOUT   = 1024;
    localparam int unsigned LINE_IDX_W    = 8;

    typedef logic [2:0] pick_ctrl_state_t;

    localparam pick_ctrl_state_t ST_IDLE     = 3'd0;
    localparam pick_ctrl_state_t ST_ISSUE    = 3'd1;
    localparam pick_ctrl_state_t ST_WAIT_HDR = 3'd2;
    localparam pick_ctrl_state_t ST_BURST    = 3'd3;
    localparam pick_ctrl_state_t ST_DONE     = 3'd4;
    localparam pick_ctrl_state_t ST_ERR      = 3'd5;

    function automatic logic state_busy(input pick_ctrl_state_t s);
        return (s != ST_IDLE) && (s != ST_ERR);
    endfunction

endpackage

// File: rtl/pick_ctrl_if.sv
// pick_ctrl_if -- picker control bus between a frame requester and pick_ctrl.
//   START/ABORT/PUSH : requests and pixel strobe into the controller
//   GO/BUSY/LINE_DONE/FRAME_DONE/TIMEOUT_ERR/LINE_IDX : controller status
//   FRAME_CNT/ERR_CNT : statistics, present only with PICK_CTRL_STATS_EN
// Modports: master (drives requests), slave (the controller).
interface pick_ctrl_if;
    import pick_pkg::*;

    logic                  START;
    logic                  ABORT;
    logic                  PUSH;
    logic                  GO;
    logic                  BUSY;
    logic                  LINE_DONE;
    logic                  FRAME_DONE;
    logic                  TIMEOUT_ERR;
    logic [LINE_IDX_W-1:0] LINE_IDX;
`ifdef PICK_CTRL_STATS_EN
    logic [15:0]           FRAME_CNT;
    logic [7:0]            ERR_CNT;
`endif

    modport master (
`ifdef PICK_CTRL_STATS_EN
        input  FRAME_CNT, ERR_CNT,
`endif
        output START, ABORT, PUSH,
        input  GO, BUSY, LINE_DONE, FRAME_DONE, TIMEOUT_ERR, LINE_IDX
    );

    modport slave (
`ifdef PICK_CTRL_STATS_EN
        output FRAME_CNT, ERR_CNT,
`endif
        input  START, ABORT, PUSH,
        output GO, BUSY, LINE_DONE, FRAME_DONE, TIMEOUT_ERR, LINE_IDX
    );

endinterface

// File: rtl/pick_wdog.sv
// pick_wdog -- header watchdog for the pick controller.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : zero the count
//   enable   : count one cycle
//   expire   : the count reaches TIMEOUT-1 on this enabled cycle
module pick_wdog
    import pick_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned   W    = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // Expire is flagged on the cycle whose increment lands on TIMEOUT-1,
    // so the caller can act on it in the same cycle.
    assign expire = enable && ((count + 1'b1) == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pick_ctrl.sv
// pick_ctrl -- requests line bursts from a pixel picker and tracks a frame.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : pick_ctrl_if.slave (START, ABORT, PUSH in; GO, BUSY, LINE_DONE,
//              FRAME_DONE, TIMEOUT_ERR, LINE_IDX out)
// Optional: define PICK_CTRL_STATS_EN to add FRAME_CNT (wrapping) and
// ERR_CNT (saturating) statistics outputs on the bus.
module pick_ctrl
    import pick_pkg::*;
#(
    parameter int unsigned NUM_PIX   = DEF_NUM_PIX,
    parameter int unsigned NUM_LINES = DEF_NUM_LINES,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic       CLK,
    input  logic       RST,
    pick_ctrl_if.slave bus
);

    localparam int unsigned              PIX_W     = $clog2(NUM_PIX + 1);
    localparam logic [PIX_W-1:0]         PIX_LAST  = PIX_W'(NUM_PIX);
    localparam logic [LINE_IDX_W-1:0]    LINE_LAST = LINE_IDX_W'(NUM_LINES - 1);

    pick_ctrl_state_t          state, state_nxt;
    logic [PIX_W-1:0]          pix_cnt, pix_cnt_nxt, cnt_after;
    logic [LINE_IDX_W-1:0]     line_idx, line_idx_nxt;
    logic                      line_done, line_done_nxt;
    logic                      wd_clear, wd_enable, wd_expire;

    assign wd_clear  = (state == ST_ISSUE);
    assign wd_enable = (state == ST_WAIT_HDR);

    pick_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (CLK),
        .rst    (RST),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (wd_expire)
    );

    // The first PUSH in WAIT_HDR and each PUSH in BURST share one path: the
    // pixel count after this cycle's PUSH decides whether the line completes.
    assign cnt_after = (state == ST_BURST) ? pix_cnt + 1'b1 : PIX_W'(1);

    always_comb begin
        state_nxt     = state;
        pix_cnt_nxt   = pix_cnt;
        line_idx_nxt  = line_idx;
        line_done_nxt = 1'b0;
        if (bus.ABORT) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.START) begin
                        state_nxt    = ST_ISSUE;
                        line_idx_nxt = '0;
                    end
                end
                ST_ISSUE: begin
                    pix_cnt_nxt = '0;
                    state_nxt   = bus.PUSH ? ST_ERR : ST_WAIT_HDR;
                end
                ST_WAIT_HDR, ST_BURST: begin
                    if (bus.PUSH) begin
                        if (cnt_after == PIX_LAST) begin
                            line_done_nxt = 1'b1;
                            pix_cnt_nxt   = '0;
                            if (line_idx == LINE_LAST) begin
                                state_nxt = ST_DONE;
                            end else begin
                                line_idx_nxt = line_idx + 1'b1;
                                state_nxt    = ST_ISSUE;
                            end
                        end else begin
                            pix_cnt_nxt = cnt_after;
                            state_nxt   = ST_BURST;
                        end
                    end else if (state == ST_BURST || wd_expire) begin
                        state_nxt = ST_ERR;
                    end
                end
                ST_DONE: state_nxt = ST_IDLE;
                ST_ERR:  state_nxt = ST_ERR;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            pix_cnt   <= '0;
            line_idx  <= '0;
            line_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            pix_cnt   <= pix_cnt_nxt;
            line_idx  <= line_idx_nxt;
            line_done <= line_done_nxt;
        end
    end

    assign bus.GO          = (state == ST_ISSUE);
    assign bus.BUSY        = state_busy(state);
    assign bus.FRAME_DONE  = (state == ST_DONE);
    assign bus.TIMEOUT_ERR = (state == ST_ERR);
    assign bus.LINE_DONE   = line_done;
    assign bus.LINE_IDX    = line_idx;

`ifdef PICK_CTRL_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
    logic        err_entry;

    assign err_entry = (state_nxt == ST_ERR) && (state != ST_ERR);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (state == ST_DONE) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (err_entry && err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign bus.FRAME_CNT = frame_cnt;
    assign bus.ERR_CNT   = err_cnt;
`endif

endmodule

// File: doc/pick_ctrl.md
PICK_CTRL -- requirements
Module: pick_ctrl

Interface
REQ-001 SHALL have parameter NUM_PIX, default 16, pixels per line burst expected from the picker.
REQ-002 SHALL have parameter NUM_LINES, default 8, line bursts per frame.
REQ-003 SHALL have parameter TIMEOUT, default 1024, max cycles from GO to first PUSH.
REQ-004 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port START  input  1  frame request pulse.
REQ-007 SHALL have port ABORT  input  1  cancel current frame or clear error.
REQ-008 SHALL have port PUSH  input  1  pixel-valid strobe from picker.
REQ-009 SHALL have port GO  output  1  one-cycle line request to picker.
REQ-010 SHALL have port BUSY  output  1  high in any state except IDLE and ERR.
REQ-011 SHALL have port LINE_DONE  output  1  one-cycle pulse per completed line.
REQ-012 SHALL have port FRAME_DONE  output  1  one-cycle pulse per completed frame.
REQ-013 SHALL have port TIMEOUT_ERR  output  1  sticky error flag, high in ERR.
REQ-014 SHALL have port LINE_IDX  output  8  index of line in progress, 0-based.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT_HDR, BURST, DONE, ERR; all outputs registered or decoded from state only.
REQ-016 IDLE: START=1 -> ISSUE, LINE_IDX<=0; START in any other state ignored.
REQ-017 ISSUE: GO=1 for exactly this one cycle, watchdog cleared, -> WAIT_HDR; PUSH=1 in ISSUE -> ERR.
REQ-018 WAIT_HDR: watchdog increments per cycle; PUSH=1 -> BURST with pixel count 1; watchdog reaching TIMEOUT-1 without PUSH -> ERR; PUSH wins if both coincide.
REQ-019 BURST: each PUSH cycle increments pixel count; PUSH=0 before count reaches NUM_PIX -> ERR (broken burst).
REQ-020 On count reaching NUM_PIX: LINE_DONE pulses next cycle; if LINE_IDX==NUM_LINES-1 -> DONE, else LINE_IDX+1 and -> ISSUE.
REQ-021 DONE: FRAME_DONE=1 for one cycle, -> IDLE, LINE_IDX holds last value.
REQ-022 ERR: TIMEOUT_ERR=1, GO=0, remains until ABORT=1 -> IDLE.
REQ-023 ABORT=1 in any state -> IDLE next cycle, highest priority, no GO/LINE_DONE/FRAME_DONE issued that cycle.
REQ-024 Pixel count SHALL be ceil(log2(NUM_PIX+1)) bits, watchdog ceil(log2(TIMEOUT+1)) bits; no wrap-around possible in legal operation.
REQ-025 PUSH in IDLE, DONE, ERR SHALL be ignored.

Reset
REQ-026 RST=1 SHALL force IDLE asynchronously; GO, BUSY, LINE_DONE, FRAME_DONE, TIMEOUT_ERR = 0, LINE_IDX = 0, counters = 0.
REQ-027 RST asserted mid-frame SHALL abandon the frame; no done pulse after release.

Configuration
REQ-028 Macro PICK_CTRL_STATS_EN defined: SHALL add outputs FRAME_CNT[15:0] (increments on FRAME_DONE, wraps 0xFFFF->0) and ERR_CNT[7:0] (increments on ERR entry, saturates at 0xFF), both reset to 0.
REQ-029 Macro undefined: SHALL have neither port nor counter; all other behaviour identical.

Structure
REQ-030 Package pick_pkg SHALL hold state typedef pick_ctrl_state_t and shared default constants (NUM_PIX, NUM_LINES, TIMEOUT).
REQ-031 Watchdog SHALL be sub-module pick_wdog (clear, enable, expire at TIMEOUT-1).

Verification (NUM_PIX=4, NUM_LINES=2, TIMEOUT=8)
REQ-032 START, picker model returns 4 PUSH 3 cycles after each GO -> 2 GO pulses, LINE_DONE x2, LINE_IDX 0->1, FRAME_DONE once, BUSY low after.
REQ-033 START, no PUSH ever -> ERR 8 cycles after GO, TIMEOUT_ERR=1, GO stays 0; ABORT -> IDLE, TIMEOUT_ERR=0.
REQ-034 START, burst PUSH 1,1,0 -> ERR on third cycle, no LINE_DONE.
REQ-035 ABORT asserted during BURST of line 1 -> IDLE next cycle, no FRAME_DONE; START again completes normal frame.
REQ-036 RST pulse in WAIT_HDR -> all outputs 0 immediately; START while BUSY ignored (single GO only).
REQ-037 With PICK_CTRL_STATS_EN: 3 good frames + 1 timeout -> FRAME_CNT=3, ERR_CNT=1.
